kbd_axil_subordinate: RTL and testbench



---
 rtl/kbd_axil_subordinate.sv | 223 ++++++++++++++++++++++
 tb/tb_kbd_axil_subordinate.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_axil_subordinate.sv
// AXI4-Lite register block for the keyboard peripheral: CTRL/STATUS/DATA/SCRATCH plus scancode FIFO.
// Optional irq output is built when KBD_AXIL_IRQ_EN is defined.
module kbd_axil_subordinate #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            key_valid,
   input  logic [7:0]                      key_code
`ifdef KBD_AXIL_IRQ_EN
   ,
   output logic                            irq
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {W_INIT, W_IDLE, W_RESP} wstate_e;
   typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rstate_e;

   wstate_e        w_state_q, w_state_d;
   rstate_e        r_state_q, r_state_d;

   logic           aw_pend_q, w_pend_q;
   logic [1:0]     awaddr_q;
   logic [31:0]    wdata_q;
   logic [3:0]     wstrb_q;

   logic           aw_hs, w_hs, ar_hs, wr_en;
   logic [1:0]     wr_addr;
   logic [31:0]    wr_data;
   logic [3:0]     wr_strb;

   logic           en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
   logic [31:0]    scratch_q, scratch_d, rdata_q, rd_mux;
   logic           flush, ovf_clr;

   logic [7:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [7:0]     count_byte;
   logic           empty, full, push_req, push, pop;

   logic           unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // A channel that has already handshaked drops its READY until the pair completes.
   assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_pend_q;
   assign S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_pend_q;
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = (r_state_q == R_IDLE);
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RDATA   = rdata_q;

   assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
   assign wr_en   = (w_state_q == W_IDLE) && (aw_pend_q || aw_hs) && (w_pend_q || w_hs);
   assign wr_addr = aw_pend_q ? awaddr_q : S_AXI_AWADDR[3:2];
   assign wr_data = w_pend_q ? wdata_q : S_AXI_WDATA;
   assign wr_strb = w_pend_q ? wstrb_q : S_AXI_WSTRB;

   always_comb begin
      w_state_d = w_state_q;
      unique case (w_state_q)
         W_INIT:  w_state_d = W_IDLE;
         W_IDLE:  if (wr_en) w_state_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      unique case (r_state_q)
         R_INIT:  r_state_d = R_IDLE;
         R_IDLE:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      en_d      = en_q;
      irq_en_d  = irq_en_q;
      scratch_d = scratch_q;
      flush     = 1'b0;
      ovf_clr   = 1'b0;
      if (wr_en) begin
         unique case (wr_addr)
            2'd0: if (wr_strb[0]) begin
               en_d     = wr_data[0];
               flush    = wr_data[1];
               irq_en_d = wr_data[2];
            end
            2'd1: ovf_clr = wr_strb[0] && wr_data[2];
            2'd3: for (int unsigned i = 0; i < 4; i++)
               if (wr_strb[i]) scratch_d[8*i +: 8] = wr_data[8*i +: 8];
            default: ;
         endcase
      end
   end

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign pop      = ar_hs && (S_AXI_ARADDR[3:2] == 2'd2) && !empty;
   assign push_req = key_valid && en_q;
   // A concurrent pop frees the slot, so a push into a full FIFO still lands.
   assign push     = push_req && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (push_req && full && !pop) ovf_d = 1'b1;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   assign count_byte = 8'(count_q);

   always_comb begin
      rd_mux = '0;
      unique case (S_AXI_ARADDR[3:2])
         2'd0: rd_mux = {29'b0, irq_en_q, 1'b0, en_q};
         2'd1: rd_mux = {16'b0, count_byte, 5'b0, ovf_q, full, empty};
         2'd2: rd_mux = empty ? '0 : {23'b0, 1'b1, mem_q[rd_ptr_q]};
         default: rd_mux = scratch_q;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (push && !flush) mem_q[wr_ptr_q] <= key_code;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state_q <= W_INIT;
         r_state_q <= R_INIT;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
         scratch_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         if (wr_en) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_pend_q <= 1'b1;
               awaddr_q  <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
               w_pend_q <= 1'b1;
               wdata_q  <= S_AXI_WDATA;
               wstrb_q  <= S_AXI_WSTRB;
            end
         end
         if (ar_hs) rdata_q <= rd_mux;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         ovf_q     <= ovf_d;
         scratch_q <= scratch_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

`ifdef KBD_AXIL_IRQ_EN
   logic irq_q;
   always_ff @(posedge ACLK) begin
      if (ARESET) irq_q <= 1'b0;
      else        irq_q <= irq_en_q && (!empty || ovf_q);
   end
   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_kbd_axil_subordinate.sv
// Self-checking bench for kbd_axil_subordinate: directed vector table, hand sequences, random ops vs queue model.
module tb_kbd_axil_subordinate;

   localparam int DEPTH = 16;
   localparam int TMO   = 50;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        ARESET;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        key_valid;
   logic [7:0]  key_code;
`ifdef KBD_AXIL_IRQ_EN
   logic        irq;
`endif

   kbd_axil_subordinate #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
      .ACLK(clk), .ARESET(ARESET),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .key_valid(key_valid), .key_code(key_code)
`ifdef KBD_AXIL_IRQ_EN
      , .irq(irq)
`endif
   );

   int checks = 0;
   int errors = 0;
   int rd_lat = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles", nm, TMO);
   endtask

   // Reference model: the FIFO is a plain queue of scancodes.
   logic [7:0]  mq[$];
   bit          m_en, m_irq, m_ovf;
   logic [31:0] m_scr;

   task automatic m_reset();
      mq.delete();
      m_en = 0; m_irq = 0; m_ovf = 0; m_scr = '0;
   endtask

   task automatic m_push(input logic [7:0] c);
      if (m_en) begin
         if (mq.size() < DEPTH) mq.push_back(c);
         else m_ovf = 1;
      end
   endtask

   task automatic m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      case (a[3:2])
         2'd0: if (s[0]) begin
            m_en = d[0]; m_irq = d[2];
            if (d[1]) mq.delete();
         end
         2'd1: if (s[0] && d[2]) m_ovf = 0;
         2'd3: for (int i = 0; i < 4; i++) if (s[i]) m_scr[8*i +: 8] = d[8*i +: 8];
         default: ;
      endcase
   endtask

   task automatic m_read(input logic [3:0] a, output logic [31:0] v);
      logic [7:0] b;
      int n;
      n = mq.size();
      case (a[3:2])
         2'd0: v = {29'b0, m_irq, 1'b0, m_en};
         2'd1: v = 32'(n) * 256 + (m_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
         2'd2: if (n > 0) begin
            b = mq.pop_front();
            v = {23'b0, 1'b1, b};
         end else v = '0;
         default: v = m_scr;
      endcase
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      logic ah, wh;
      bit done;
      resp = 2'bxx;
      @(posedge clk); #1;
      awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
      n = 0;
      while (awvalid || wvalid) begin
         @(negedge clk);
         ah = awready; wh = wready;
         @(posedge clk); #1;
         if (ah) awvalid = 0;
         if (wh) wvalid = 0;
         n++;
         if (n > TMO) begin timeout("aw_w_hs"); awvalid = 0; wvalid = 0; end
      end
      done = 0; n = 0;
      while (!done) begin
         @(negedge clk);
         if (bvalid) begin resp = bresp; done = 1; end
         @(posedge clk); #1;
         n++;
         if (!done && n > TMO) begin timeout("bvalid"); done = 1; end
      end
      bready = 0;
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      bit done;
      d = 'x; resp = 2'bxx;
      @(posedge clk); #1;
      araddr = a; arvalid = 1; rready = 1;
      done = 0; n = 0;
      while (!done) begin
         @(negedge clk);
         if (arready) done = 1;
         @(posedge clk); #1;
         n++;
         if (!done && n > TMO) begin timeout("ar_hs"); done = 1; end
      end
      arvalid = 0;
      done = 0; n = 0;
      while (!done) begin
         @(negedge clk);
         if (rvalid) begin d = rdata; resp = rresp; done = 1; rd_lat = n; end
         @(posedge clk); #1;
         n++;
         if (!done && n > TMO) begin timeout("rvalid"); done = 1; end
      end
      rready = 0;
   endtask

   task automatic push_key(input logic [7:0] c);
      @(posedge clk); #1;
      key_valid = 1; key_code = c;
      @(posedge clk); #1;
      key_valid = 0;
      m_push(c);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
      logic [1:0] r;
      axi_write(a, d, s, r);
      m_write(a, d, s);
      chk({nm, "_bresp"}, {30'b0, r}, 32'h0);
   endtask

   task automatic do_read(input logic [3:0] a, input string nm);
      logic [31:0] got, exp;
      logic [1:0]  r;
      axi_read(a, got, r);
      m_read(a, exp);
      chk(nm, got, exp);
      chk({nm, "_rresp"}, {30'b0, r}, 32'h0);
   endtask

   task automatic rd_const(input logic [3:0] a, input logic [31:0] exp, input string nm);
      logic [31:0] got, mexp;
      logic [1:0]  r;
      axi_read(a, got, r);
      m_read(a, mexp);
      chk(nm, got, exp);
   endtask

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [31:0] got, d, hold;
      logic [1:0]  r;
      logic [3:0]  a, s;
      int unsigned op;

      tbl[0]  = '{1'b1, 4'hC, 32'hDEADBEEF, 4'hF, 32'h0};
      tbl[1]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 4'hC, 32'h00000011, 4'h1, 32'h0};
      tbl[3]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'hDEADBE11};
      tbl[4]  = '{1'b1, 4'hD, 32'h0000AB00, 4'h2, 32'h0};
      tbl[5]  = '{1'b0, 4'hF, 32'h0,        4'h0, 32'hDEADAB11};
      tbl[6]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0};
      tbl[7]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h00000001};
      tbl[8]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h0};
      tbl[9]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, 32'h0};
      tbl[10] = '{1'b0, 4'h5, 32'h0,        4'h0, 32'h00000001};
      tbl[11] = '{1'b1, 4'h0, 32'h00000004, 4'hF, 32'h0};
      tbl[12] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h00000004};
      tbl[13] = '{1'b1, 4'h0, 32'h00000000, 4'hF, 32'h0};

      ARESET = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
      bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0; key_valid = 0; key_code = 0;
      m_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", {31'b0, awready}, 0);
      chk("rst_wready",  {31'b0, wready},  0);
      chk("rst_arready", {31'b0, arready}, 0);
      chk("rst_bvalid",  {31'b0, bvalid},  0);
      chk("rst_rvalid",  {31'b0, rvalid},  0);
      chk("rst_rdata",   rdata, 0);
      chk("rst_resp",    {28'b0, bresp, rresp}, 0);
      @(posedge clk); #1;
      ARESET = 0;

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
            m_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            chk($sformatf("tbl%0d_bresp", i), {30'b0, r}, tbl[i].exp);
         end else begin
            axi_read(tbl[i].addr, got, r);
            m_read(tbl[i].addr, d);
            chk($sformatf("tbl%0d_rdata", i), got, tbl[i].exp);
            chk($sformatf("tbl%0d_rresp", i), {30'b0, r}, 0);
         end
      end

      // AW leads W by three cycles; exactly one B beat, one cycle after the W handshake.
      @(posedge clk); #1;
      awaddr = 4'h0; awvalid = 1; bready = 1;
      @(negedge clk);
      chk("dec_awready", {31'b0, awready}, 1);
      @(posedge clk); #1;
      awvalid = 0;
      repeat (2) begin
         @(negedge clk);
         chk("dec_no_b_early", {31'b0, bvalid}, 0);
         @(posedge clk); #1;
      end
      wdata = 32'h1; wstrb = 4'hF; wvalid = 1;
      @(negedge clk);
      chk("dec_wready", {31'b0, wready}, 1);
      chk("dec_no_b_before_w", {31'b0, bvalid}, 0);
      @(posedge clk); #1;
      wvalid = 0;
      @(negedge clk);
      chk("dec_bvalid", {31'b0, bvalid}, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("dec_single_b", {31'b0, bvalid}, 0);
      @(posedge clk); #1;
      bready = 0;
      m_write(4'h0, 32'h1, 4'hF);
      rd_const(4'h0, 32'h1, "dec_ctrl");

      push_key(8'h1C); push_key(8'h32); push_key(8'h21);
      rd_const(4'h4, 32'h0300, "ord_status");
      rd_const(4'h8, 32'h11C, "ord_d0");
      chk("rd_latency", rd_lat, 0);
      rd_const(4'h8, 32'h132, "ord_d1");
      rd_const(4'h8, 32'h121, "ord_d2");
      rd_const(4'h8, 32'h0,   "ord_d3_empty");
      rd_const(4'h4, 32'h1,   "ord_status_empty");

      do_write(4'h0, 32'h3, 4'hF, "ovf_en");
      for (int i = 0; i < 17; i++) push_key(8'(8'h40 + i));
      rd_const(4'h4, 32'h1006, "ovf_status");
      do_write(4'h4, 32'h4, 4'hF, "ovf_w1c");
      rd_const(4'h4, 32'h1002, "ovf_cleared");

      // Push arrives on the same edge as the DATA AR handshake of a full FIFO.
      @(posedge clk); #1;
      araddr = 4'h8; arvalid = 1; rready = 1; key_valid = 1; key_code = 8'h99;
      @(negedge clk);
      chk("sim_arready", {31'b0, arready}, 1);
      @(posedge clk); #1;
      arvalid = 0; key_valid = 0;
      @(negedge clk);
      chk("sim_rvalid", {31'b0, rvalid}, 1);
      m_read(4'h8, d);
      m_push(8'h99);
      chk("sim_rdata", rdata, 32'h140);
      @(posedge clk); #1;
      rready = 0;
      rd_const(4'h4, 32'h1002, "sim_status");
      for (int i = 0; i < 16; i++) do_read(4'h8, $sformatf("drain%0d", i));
      rd_const(4'h4, 32'h1, "drain_empty");

      push_key(8'h11); push_key(8'h22); push_key(8'h33);
      do_write(4'h0, 32'h3, 4'hF, "flush_wr");
      rd_const(4'h4, 32'h1, "flush_status");
      rd_const(4'h0, 32'h1, "flush_ctrl");

      // R channel backpressure: RDATA/RVALID must hold while RREADY is low.
      push_key(8'h5A);
      @(posedge clk); #1;
      araddr = 4'h8; arvalid = 1; rready = 0;
      @(posedge clk); #1;
      arvalid = 0;
      m_read(4'h8, hold);
      repeat (5) begin
         @(negedge clk);
         chk("bp_rvalid", {31'b0, rvalid}, 1);
         chk("bp_rdata", rdata, 32'h15A);
         @(posedge clk); #1;
      end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      @(negedge clk);
      chk("bp_released", {31'b0, rvalid}, 0);

      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 9);
         a  = 4'($urandom);
         if (op < 4) push_key(8'($urandom));
         else if (op < 7) do_read(a, "rnd_rd");
         else begin
            d = $urandom; s = 4'($urandom);
            if (a[3:2] == 2'd0 && $urandom_range(0, 3) != 0) begin d[0] = 1; d[1] = 0; end
            do_write(a, d, s, "rnd_wr");
         end
      end

      // Reset while a write response is pending.
      @(posedge clk); #1;
      awaddr = 4'hC; awvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1; bready = 0;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      @(negedge clk);
      chk("mid_bvalid", {31'b0, bvalid}, 1);
      @(posedge clk); #1;
      ARESET = 1;
      @(negedge clk);
      chk("mid_rst_bvalid", {31'b0, bvalid}, 1);
      @(posedge clk); #1;
      chk("mid_rst_bvalid_cleared", {31'b0, bvalid}, 0);
      ARESET = 0;
      m_reset();
      repeat (3) begin
         @(negedge clk);
         chk("mid_no_b", {31'b0, bvalid}, 0);
      end
      rd_const(4'h0, 32'h0, "rst_ctrl");
      rd_const(4'h4, 32'h1, "rst_status");
      rd_const(4'h8, 32'h0, "rst_data");
      rd_const(4'hC, 32'h0, "rst_scratch");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
